two_client_request_tracker: RTL and testbench
=============================================

Name: two_client_request_tracker

Overview:
Requester-side companion to the 2-request round-robin arbiter; drives the arbiter's `requests` vector and consumes its `grants` vector. Each of two clients posts single-cycle job pulses. The block keeps a saturating pending-job counter per client and holds that client's request high while its counter is non-zero. Each accepted grant retires one job and is reported to the client as a `served` pulse.

Parameters:
- MAX_PENDING, 7, maximum outstanding jobs per client; must be >= 1.
- CNT_W, $clog2(MAX_PENDING+1), derived width of each pending counter; not to be overridden.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous, active-high reset.
- new_req, input, 2, bit i = one new job for client i this cycle (pulse per job).
- grants, input, 2, from the arbiter; combinational response to `requests` in the same cycle.
- requests, output, 2, to the arbiter; bit i = (pending_i != 0); driven directly from registers.
- served, output, 2, registered; bit i = 1 for one cycle after a grant to client i was accepted.
- pending_0, output, CNT_W, current job count for client 0.
- pending_1, output, CNT_W, current job count for client 1.
- overflow, output, 2, sticky; bit i set when a client-i job is dropped at saturation.
- spurious_grant, output, 1, sticky error flag; see Optional Feature.

Behaviour:
- Reset (async, immediate on rst=1): pending_0 = pending_1 = 0, requests = 00, served = 00, overflow = 00, spurious_grant = 0. All outputs hold these values while rst=1.
- Accept condition for client i: acc_i = grants[i] & requests[i], evaluated at posedge.
  - A grant on a line whose request is 0 is ignored: no counter change, no served pulse.
- Counter update per client, per posedge:
  - new_req=0, acc=0: hold.
  - new_req=1, acc=0: increment if pending < MAX_PENDING. If pending == MAX_PENDING: hold, drop the job, set overflow[i].
  - new_req=0, acc=1: decrement. Never underflows, because acc implies pending != 0.
  - new_req=1, acc=1: hold, including at MAX_PENDING. No overflow in this case.
- requests[i] equals (pending_i != 0) and is combinational from registered state.
  - A job posted in cycle N raises requests[i] in cycle N+1.
  - A grant accepted when pending == 1 (with no new_req) drops requests[i] in the next cycle.
- served[i] <= acc_i. One pulse per accepted grant, one-cycle latency.
- Both clients are independent. Simultaneous grants to both (an arbiter error) are accepted on both lines. Arbitration policy stays in the arbiter; this block never masks requests.
- overflow bits stay set until rst.
- The block does not check grant exclusivity unless the optional feature is enabled.

Optional Feature:
- Macro: TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN.
- Defined:
  - spurious_grant is set at posedge when (grants & ~requests) != 00, or when grants == 11. It is sticky until rst.
  - Also emits a $error in simulation.
- Undefined:
  - spurious_grant is tied to 0 and no checking logic is built.
  - Grant handling is otherwise identical in both builds.

Test Plan:
1. Pulse new_req=01 for 3 cycles with grants=00 -> pending_0 goes 1,2,3; requests=01 from the cycle after the first pulse; served=00.
2. From pending_0=3, hold grants=01 for 3 cycles -> pending_0 goes 2,1,0; served[0]=1 for 3 consecutive cycles. requests=00 the cycle after the third grant. A fourth grant=01 -> no change, no served pulse.
3. pending_1=2, drive new_req=10 and grants=10 in the same cycle -> pending_1 stays 2, served=10 next cycle, overflow=00.
4. With MAX_PENDING=7, pulse new_req=11 for 9 cycles with grants=00 -> both counters 7; overflow=11 from the 8th pulse and still 11 after 20 more idle cycles.
5. With pending_0=5 and pending_1=3, assert rst mid-cycle (not on an edge) -> all outputs 0 immediately. Deassert, pulse new_req=01 once -> pending_0=1, requests=01.
6. requests=00, drive grants=10 -> counters unchanged, served=00. With TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN: spurious_grant=1 next cycle and sticky. Without it: spurious_grant stays 0.

Source files
------------

// File: rtl/two_client_request_tracker.sv
// two_client_request_tracker
// Requester-side companion to a 2-request round-robin arbiter. Each client
// posts single-cycle job pulses; a saturating pending counter per client keeps
// that client's request asserted until every job has been granted. Each
// accepted grant retires one job and returns a one-cycle served pulse.
//
// Build option: define TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN to build a sticky
// spurious_grant flag (grant on an idle line, or both lines granted at once).
// Without it spurious_grant is tied low and no checking logic exists.
module two_client_request_tracker #(
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       new_req,
  input  logic [1:0]       grants,
  output logic [1:0]       requests,
  output logic [1:0]       served,
  output logic [CNT_W-1:0] pending_0,
  output logic [CNT_W-1:0] pending_1,
  output logic [1:0]       overflow,
  output logic             spurious_grant
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  // Saturating counter step. Returns {drop, next_count}; drop is set when a
  // new job arrives at saturation with no simultaneous retirement.
  function automatic logic [CNT_W:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == MAX_CNT) r = {1'b1, cnt};
      else                r = {1'b0, cnt + 1'b1};
    end else if (!inc && dec) begin
      // dec implies the request was up, so cnt is non-zero here
      r = {1'b0, cnt - 1'b1};
    end
    return r;
  endfunction

  logic [CNT_W-1:0] cnt_p0 [2];
  logic [1:0]       served_p0;
  logic [1:0]       overflow_p0;
  logic [1:0]       acc;
  logic [CNT_W:0]   upd [2];

  // A grant only counts on a line that is actually requesting.
  assign acc = grants & requests;

  // Next counter value and drop indication for each client.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      upd[i] = sat_update(cnt_p0[i], new_req[i], acc[i]);
    end
  end

  // ---- register stage p0: counters, served pulses, sticky overflow ----
  // Counter, served and overflow state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0[0]   <= '0;
      cnt_p0[1]   <= '0;
      served_p0   <= 2'b00;
      overflow_p0 <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_p0[i]      <= upd[i][CNT_W-1:0];
        overflow_p0[i] <= overflow_p0[i] | upd[i][CNT_W];
      end
      served_p0 <= acc;
    end
  end

  assign requests  = {(cnt_p0[1] != '0), (cnt_p0[0] != '0)};
  assign served    = served_p0;
  assign pending_0 = cnt_p0[0];
  assign pending_1 = cnt_p0[1];
  assign overflow  = overflow_p0;

`ifdef TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN
  logic spur_p0;
  logic bad_grant;

  assign bad_grant = (|(grants & ~requests)) | (&grants);

  // Sticky flag for grants the arbiter should never have issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            spur_p0 <= 1'b0;
    else if (bad_grant) spur_p0 <= 1'b1;
  end

  assign spurious_grant = spur_p0;

`ifndef SYNTHESIS
  // Simulation-only report of each offending grant.
  always @(posedge clk) begin
    if (!rst && bad_grant)
      $error("two_client_request_tracker: spurious grant %b with requests %b", grants, requests);
  end
`endif
`else
  assign spurious_grant = 1'b0;
`endif

endmodule

// File: tb/tb_two_client_request_tracker.sv
// Self-checking bench for two_client_request_tracker: directed scenarios
// followed by randomized traffic, all compared against a job-count model.
module tb_two_client_request_tracker;

  localparam int MAX_PENDING = 7;
  localparam int CNT_W       = $clog2(MAX_PENDING + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       new_req = 2'b00;
  logic [1:0]       grants  = 2'b00;
  logic [1:0]       requests;
  logic [1:0]       served;
  logic [CNT_W-1:0] pending_0;
  logic [CNT_W-1:0] pending_1;
  logic [1:0]       overflow;
  logic             spurious_grant;

  int checks   = 0;
  int failures = 0;

  // Reference model state: job counts and flags
  int   m_pend [2];
  logic [1:0] m_served;
  logic [1:0] m_ovf;
  logic       m_spur;

  two_client_request_tracker #(.MAX_PENDING(MAX_PENDING)) dut (
    .clk(clk), .rst(rst), .new_req(new_req), .grants(grants),
    .requests(requests), .served(served), .pending_0(pending_0),
    .pending_1(pending_1), .overflow(overflow), .spurious_grant(spurious_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend[0] = 0; m_pend[1] = 0;
    m_served = 2'b00; m_ovf = 2'b00; m_spur = 1'b0;
  endtask

  function automatic logic [1:0] model_req();
    return {logic'(m_pend[1] > 0), logic'(m_pend[0] > 0)};
  endfunction

  // One clock edge of the job-counting rules.
  task automatic model_step(input logic [1:0] nr, input logic [1:0] g);
    logic [1:0] req;
    req = model_req();
`ifdef TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN
    if ((g & ~req) != 2'b00 || g == 2'b11) m_spur = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      logic a;
      a = g[i] && req[i];
      m_served[i] = a;
      if (nr[i] && !a) begin
        if (m_pend[i] < MAX_PENDING) m_pend[i] = m_pend[i] + 1;
        else                         m_ovf[i] = 1'b1;
      end else if (!nr[i] && a) begin
        m_pend[i] = m_pend[i] - 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pending_0"}, 32'(pending_0), 32'(m_pend[0]));
    check({tag, ".pending_1"}, 32'(pending_1), 32'(m_pend[1]));
    check({tag, ".requests"},  32'(requests),  32'(model_req()));
    check({tag, ".served"},    32'(served),    32'(m_served));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".spurious"},  32'(spurious_grant), 32'(m_spur));
  endtask

  // Called just after a negedge: drive, clock, then compare at next negedge.
  task automatic cycle(input string tag, input logic [1:0] nr, input logic [1:0] g);
    new_req = nr;
    grants  = g;
    @(posedge clk);
    model_step(nr, g);
    @(negedge clk);
    new_req = 2'b00;
    grants  = 2'b00;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all("reset_release");

    // 1: three jobs for client 0
    for (int k = 0; k < 3; k++) begin
      cycle("t1", 2'b01, 2'b00);
      check("t1.pend0_seq", 32'(pending_0), 32'(k + 1));
      check("t1.req", 32'(requests), 32'd1);
    end

    // 2: three grants retire them, a fourth grant is ignored
    for (int k = 0; k < 3; k++) begin
      cycle("t2", 2'b00, 2'b01);
      check("t2.pend0_seq", 32'(pending_0), 32'(2 - k));
      check("t2.served", 32'(served), 32'd1);
    end
    check("t2.req_drop", 32'(requests), 32'd0);
    cycle("t2_extra", 2'b00, 2'b01);
    check("t2.extra_served", 32'(served), 32'd0);
    check("t2.extra_pend0", 32'(pending_0), 32'd0);

    // 3: simultaneous job and grant on client 1 holds the count
    cycle("t3a", 2'b10, 2'b00);
    cycle("t3b", 2'b10, 2'b00);
    cycle("t3c", 2'b10, 2'b10);
    check("t3.pend1", 32'(pending_1), 32'd2);
    check("t3.served", 32'(served), 32'd2);
    check("t3.ovf", 32'(overflow), 32'd0);

    // 4: saturation and sticky overflow
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      cycle("t4", 2'b11, 2'b00);
      check("t4.ovf_seq", 32'(overflow), (k >= 8) ? 32'd3 : 32'd0);
    end
    check("t4.pend0", 32'(pending_0), 32'd7);
    check("t4.pend1", 32'(pending_1), 32'd7);
    repeat (20) cycle("t4_idle", 2'b00, 2'b00);
    check("t4.ovf_sticky", 32'(overflow), 32'd3);
    // saturated count with job plus grant holds, no new overflow effect
    cycle("t4_hold", 2'b01, 2'b01);
    check("t4.hold_pend0", 32'(pending_0), 32'd7);

    // 5: asynchronous reset in mid-cycle
    do_reset();
    repeat (3) cycle("t5_fill", 2'b11, 2'b00);
    repeat (2) cycle("t5_fill0", 2'b01, 2'b00);
    check("t5.pend0_pre", 32'(pending_0), 32'd5);
    check("t5.pend1_pre", 32'(pending_1), 32'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all("t5_async");
    @(negedge clk);
    rst = 1'b0;
    cycle("t5_post", 2'b01, 2'b00);
    check("t5.pend0_post", 32'(pending_0), 32'd1);
    check("t5.req_post", 32'(requests), 32'd1);

    // 6: grant on an idle line
    do_reset();
    cycle("t6", 2'b00, 2'b10);
    cycle("t6_after", 2'b00, 2'b00);
`ifdef TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN
    check("t6.spur", 32'(spurious_grant), 32'd1);
`else
    check("t6.spur", 32'(spurious_grant), 32'd0);
`endif

    // Randomized traffic; grants mostly follow the model's requests
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [1:0] nr, g, r;
      nr = 2'($urandom);
      r  = model_req();
      g  = 2'($urandom) & r;
`ifndef TWO_CLIENT_SPURIOUS_GRANT_CHECK_EN
      if ($urandom_range(0, 7) == 0) g = 2'($urandom);
`else
      if (g == 2'b11) g = 2'b01;
`endif
      // Occasionally idle out to drain the counters
      if (k % 50 > 40) nr = 2'b00;
      cycle("rand", nr, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound total run time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
